// File: rtl/wb_trace_checker.sv
// wb_trace_checker
//   Consumer end of the CPU debug write-back trace (debug_wb_*). Each retired
//   instruction is compared against a golden trace held in a combinational-read
//   memory addressed by gold_addr. Reports pass/fail, first-error details,
//   a saturating mismatch count and a stall timeout.
//
// Build option:
//   TRACE_CONT_ON_ERR_EN  when defined, a mismatch does not stop checking; the
//                         verdict is taken at the last entry. Undefined (default):
//                         the first mismatch ends checking with FAIL.
//
// Parameters:
//   TRACE_LEN  number of golden entries expected (1..2**ADDR_W)
//   ADDR_W     golden memory index width
//   TIMEOUT    max cycles without a retirement before timeout fail (>=2)
//   TO_W       timeout counter width (2**TO_W > TIMEOUT)
//
// Ports:
//   fpga_clk, fpga_rst     clock, synchronous active-high reset
//   debug_wb_have_inst     instruction retired this cycle
//   debug_wb_pc/ena/reg/value  retired instruction write-back info
//   gold_addr              golden entry index (the internal index register)
//   gold_data              {ena[69], reg[68:64], pc[63:32], value[31:0]}, same-cycle valid
//   done / pass            checking finished / finished with no error
//   err_code               00 none, 01 mismatch, 10 timeout
//   err_index              index of first error
//   err_pc / err_value     DUT pc/value of first mismatch (0 on timeout)
//   err_count              mismatch count, saturating at 16'hFFFF
module wb_trace_checker #(
  parameter int unsigned TRACE_LEN = 4096,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned TO_W      = 16
) (
  input  logic              fpga_clk,
  input  logic              fpga_rst,
  input  logic              debug_wb_have_inst,
  input  logic [31:0]       debug_wb_pc,
  input  logic              debug_wb_ena,
  input  logic [4:0]        debug_wb_reg,
  input  logic [31:0]       debug_wb_value,
  output logic [ADDR_W-1:0] gold_addr,
  input  logic [69:0]       gold_data,
  output logic              done,
  output logic              pass,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] err_index,
  output logic [31:0]       err_pc,
  output logic [31:0]       err_value,
  output logic [15:0]       err_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TRACE_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_done;
  logic              r_pass;
  logic [1:0]        r_err_code;
  logic [ADDR_W-1:0] r_err_index;
  logic [31:0]       r_err_pc;
  logic [31:0]       r_err_value;
  logic [15:0]       r_err_count;

  logic        w_g_ena;
  logic [4:0]  w_g_reg;
  logic [31:0] w_g_pc;
  logic [31:0] w_g_val;
  logic        w_d_ena_n;
  logic        w_g_ena_n;
  logic        w_match;
  logic        w_last;
  logic        w_to_expire;
  logic        w_first_err;
  logic [15:0] w_err_count_inc;

  always_comb begin
    w_g_ena   = gold_data[69];
    w_g_reg   = gold_data[68:64];
    w_g_pc    = gold_data[63:32];
    w_g_val   = gold_data[31:0];
    // A write to x0 is architecturally a no-write on both sides.
    w_d_ena_n = debug_wb_ena & (debug_wb_reg != '0);
    w_g_ena_n = w_g_ena & (w_g_reg != '0);
    // reg/value only matter when a real register write happens.
    w_match   = (debug_wb_pc == w_g_pc) && (w_d_ena_n == w_g_ena_n) &&
                (!w_d_ena_n || ((debug_wb_reg == w_g_reg) && (debug_wb_value == w_g_val)));
    w_last      = (r_idx == LAST_IDX);
    w_to_expire = (r_to_cnt == TO_LAST);
    w_first_err = (r_err_code == ERR_NONE);
    w_err_count_inc = (r_err_count == '1) ? r_err_count : r_err_count + 16'd1;
  end

  always_ff @(posedge fpga_clk) begin
    if (fpga_rst) begin
      r_state     <= ST_RUN;
      r_idx       <= '0;
      r_to_cnt    <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_index <= '0;
      r_err_pc    <= '0;
      r_err_value <= '0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (debug_wb_have_inst) begin
            // A retirement on the expiry cycle wins over the timeout.
            r_to_cnt <= '0;
            if (!w_match) begin
              r_err_count <= w_err_count_inc;
              if (w_first_err) begin
                r_err_code  <= ERR_MISMATCH;
                r_err_index <= r_idx;
                r_err_pc    <= debug_wb_pc;
                r_err_value <= debug_wb_value;
              end
            end
`ifdef TRACE_CONT_ON_ERR_EN
            if (w_last) begin
              r_done <= 1'b1;
              if (w_match && (r_err_count == '0)) begin
                r_state <= ST_PASS;
                r_pass  <= 1'b1;
              end else begin
                r_state <= ST_FAIL;
                r_pass  <= 1'b0;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
`else
            if (!w_match) begin
              r_state <= ST_FAIL;
              r_done  <= 1'b1;
              r_pass  <= 1'b0;
            end else if (w_last) begin
              r_state <= ST_PASS;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
`endif
          end else if (w_to_expire) begin
            r_state <= ST_FAIL;
            r_done  <= 1'b1;
            r_pass  <= 1'b0;
            if (w_first_err) begin
              r_err_code  <= ERR_TIMEOUT;
              r_err_index <= r_idx;
              r_err_pc    <= '0;
              r_err_value <= '0;
            end
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ST_PASS, ST_FAIL: begin
          // Terminal until reset; all outputs hold.
        end
        default: begin
          r_state <= ST_FAIL;
          r_done  <= 1'b1;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    gold_addr = r_idx;
    done      = r_done;
    pass      = r_pass;
    err_code  = r_err_code;
    err_index = r_err_index;
    err_pc    = r_err_pc;
    err_value = r_err_value;
    err_count = r_err_count;
  end

endmodule
